// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing types and default 640x480@60 constants.
// Imported by the timing generator and by pixel renderers.
package vga_timing_gen_pkg;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned MAX_TOTAL = 1 << POS_W;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef logic [POS_W-1:0] pos_t;

  function automatic int unsigned axis_total(
    input int unsigned vis,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis.
// Sync and terminal count are registered from the next position.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_END   = 752,
  parameter int unsigned TOTAL      = 800,
  parameter logic        SYNC_POL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output pos_t o_pos,
  output logic o_tc,
  output logic o_sync,
  output logic o_active_nxt
);

  localparam pos_t LAST = pos_t'(TOTAL - 1);

  pos_t pos_d;
  logic sync_d;

  always_comb begin
    pos_d = o_pos;
    if (i_en) begin
      if (o_pos == LAST) pos_d = '0;
      else               pos_d = o_pos + pos_t'(1);
    end
    o_active_nxt = 32'(pos_d) < ACTIVE;
    sync_d = ~SYNC_POL;
    if (32'(pos_d) >= SYNC_START && 32'(pos_d) < SYNC_END)
      sync_d = SYNC_POL;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pos  <= LAST;
      o_tc   <= 1'b1;
      o_sync <= ~SYNC_POL;
    end else begin
      o_pos  <= pos_d;
      o_tc   <= (pos_d == LAST);
      o_sync <= sync_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel position, visible and sync flags.
// Every output is a flop describing the same pixel.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_ce,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_visible,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_start,
  output logic       o_frame_start
);

  localparam int unsigned H_TOTAL =
    axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL =
    axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned H_SS = H_VISIBLE + H_FRONT;
  localparam int unsigned V_SS = V_VISIBLE + V_FRONT;

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: axis total exceeds 1024");
  end

  logic h_tc, v_tc;
  logic h_act_nxt, v_act_nxt;

  vga_axis_counter #(
    .ACTIVE     (H_VISIBLE),
    .SYNC_START (H_SS),
    .SYNC_END   (H_SS + H_SYNC),
    .TOTAL      (H_TOTAL),
    .SYNC_POL   (SYNC_POL)
  ) u_h (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_pix_ce),
    .o_pos        (o_hpos),
    .o_tc         (h_tc),
    .o_sync       (o_hsync),
    .o_active_nxt (h_act_nxt)
  );

  vga_axis_counter #(
    .ACTIVE     (V_VISIBLE),
    .SYNC_START (V_SS),
    .SYNC_END   (V_SS + V_SYNC),
    .TOTAL      (V_TOTAL),
    .SYNC_POL   (SYNC_POL)
  ) u_v (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_pix_ce & h_tc),
    .o_pos        (o_vpos),
    .o_tc         (v_tc),
    .o_sync       (o_vsync),
    .o_active_nxt (v_act_nxt)
  );

  // a start flag is set by the edge that leaves the last column/pixel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_visible     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_visible <= h_act_nxt & v_act_nxt;
      if (i_pix_ce) begin
        o_line_start  <= h_tc;
        o_frame_start <= h_tc & v_tc;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance plus a tiny-frame
// instance so whole-frame properties fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n, ce, rst_s, ce_s;
  logic chk_on = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  logic [9:0] hpos, vpos, hpos_s, vpos_s;
  logic vis, hs, vs, ls, fs;
  logic vis_s, hs_s, vs_s, ls_s, fs_s;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_ce(ce),
    .o_hpos(hpos), .o_vpos(vpos), .o_visible(vis),
    .o_hsync(hs), .o_vsync(vs),
    .o_line_start(ls), .o_frame_start(fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b0)
  ) u_sm (
    .i_clk(clk), .i_rst_n(rst_s), .i_pix_ce(ce_s),
    .o_hpos(hpos_s), .o_vpos(vpos_s), .o_visible(vis_s),
    .o_hsync(hs_s), .o_vsync(vs_s),
    .o_line_start(ls_s), .o_frame_start(fs_s)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  // outputs implied by a raster position: {hpos,vpos,vis,hs,vs,ls,fs}
  function automatic logic [31:0] model(
    input int h, input int v,
    input int hv, input int hf, input int hsw,
    input int vv, input int vf, input int vsw
  );
    logic a, hy, vy, l, f;
    a  = (h < hv) && (v < vv);
    hy = !((h >= hv + hf) && (h < hv + hf + hsw));
    vy = !((v >= vv + vf) && (v < vv + vf + vsw));
    l  = (h == 0);
    f  = (h == 0) && (v == 0);
    return {7'd0, 10'(h), 10'(v), a, hy, vy, l, f};
  endfunction

  int mh, mv, sh, sv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh <= 799; mv <= 524;
    end else if (ce) begin
      if (mh == 799) begin
        mh <= 0;
        mv <= (mv == 524) ? 0 : mv + 1;
      end else mh <= mh + 1;
    end
  end

  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      sh <= 14; sv <= 8;
    end else if (ce_s) begin
      if (sh == 14) begin
        sh <= 0;
        sv <= (sv == 8) ? 0 : sv + 1;
      end else sh <= sh + 1;
    end
  end

  int cyc = 0, last_fs = 0, vis_cnt = 0, vsl_cnt = 0;
  bit have_prev = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      chk("big_model",
          {7'd0, hpos, vpos, vis, hs, vs, ls, fs},
          model(mh, mv, 640, 16, 96, 480, 10, 2));
      chk("small_model",
          {7'd0, hpos_s, vpos_s, vis_s, hs_s, vs_s, ls_s, fs_s},
          model(sh, sv, 8, 2, 3, 4, 1, 2));
      if (fs_s) begin
        if (have_prev) begin
          chk("s_frame_period", cyc - last_fs, 135);
          chk("s_visible_cnt", vis_cnt, 32);
          chk("s_vsync_low_cnt", vsl_cnt, 30);
        end
        have_prev = 1;
        last_fs = cyc;
        vis_cnt = 0;
        vsl_cnt = 0;
      end
      if (vis_s) vis_cnt++;
      if (!vs_s) vsl_cnt++;
    end
  end

  task automatic wait_to(input int h, input int v);
    int n = 0;
    while (!(hpos == 10'(h) && vpos == 10'(v)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("wait_timeout", {hpos, vpos}, {10'(h), 10'(v)});
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ce = 1'b1;
    rst_s = 1'b0; ce_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hpos", hpos, 799);
    chk("rst_vpos", vpos, 524);
    chk("rst_flags", {vis, hs, vs, ls, fs}, 5'b01100);
    rst_n = 1'b1; rst_s = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("first_pos", {hpos, vpos}, 20'd0);
    chk("first_flags", {vis, ls, fs}, 3'b111);
    @(negedge clk);
    chk("second_hpos", hpos, 1);
    chk("second_fs", fs, 0);

    wait_to(639, 0);
    chk("vis_639", vis, 1);
    @(negedge clk);
    chk("vis_640", vis, 0);
    wait_to(655, 0);
    chk("hs_655", hs, 1);
    @(negedge clk);
    chk("hs_656", {hpos, 1'b0, hs}, {10'd656, 2'b00});
    n = 0;
    while (!hs && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("hs_low_cycles", n, 96);
    chk("hs_rise_hpos", hpos, 752);

    for (int i = 0; i < 2000; i++) begin
      ce = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ce = 1'b1;

    wait_to(799, 10);
    @(negedge clk);
    chk("wrap_pos", {hpos, vpos}, {10'd0, 10'd11});
    chk("wrap_starts", {ls, fs}, 2'b10);

    wait_to(0, 12);
    ce = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_pos", {hpos, vpos, ls, vis}, {10'd0, 10'd12, 2'b11});
    end
    ce = 1'b1;
    @(negedge clk);
    chk("resume_pos", {hpos, ls}, {10'd1, 1'b0});

    wait_to(300, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pos", {hpos, vpos}, {10'd799, 10'd524});
    chk("async_rst_flags", {vis, hs, vs, ls, fs}, 5'b01100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerun_pos", {hpos, vpos, fs}, {20'd0, 1'b1});
    repeat (20) @(negedge clk);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
